// File: rtl/ttt_game_ctrl.sv
// rtl/ttt_game_ctrl.sv - tic-tac-toe game controller: board, turn, move count, win/draw/timeout sequencing
module ttt_game_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 500000000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [17:0] board,
    output logic        is_main,
    output logic        board_right,
    output logic        turn_o,
    output logic [3:0]  move_cnt,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [8:0]  win_line,
    output logic        err,
    output logic        timeout
);
    localparam logic [1:0] S_MAIN  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    localparam logic [3:0] K_ZERO = 4'd0;
    localparam logic [3:0] K_STAR = 4'd10;
    localparam logic [3:0] K_HASH = 4'd11;

    localparam logic             TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    // rows, columns, diagonals as cell masks (cell k = bit k)
    localparam logic [8:0] LINES [8] = '{
        9'b000000111, 9'b000111000, 9'b111000000,
        9'b001001001, 9'b010010010, 9'b100100100,
        9'b100010001, 9'b001010100
    };

    logic [1:0]       state_q, state_d;
    logic [17:0]      board_q, board_d;
    logic             board_right_q, board_right_d;
    logic             turn_q, turn_d;
    logic [3:0]       move_cnt_q, move_cnt_d;
    logic [1:0]       winner_q, winner_d;
    logic [8:0]       win_line_q, win_line_d;
    logic             err_q, err_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] timer_q, timer_d;

    logic       key_act;
    logic       is_cell;
    logic       cell_taken;
    logic       clr_game;
    logic [1:0] mark;
    logic [8:0] cell_sel;
    logic [8:0] occupied;
    logic [8:0] mine;
    logic [8:0] win_mask;

    // codes 12..15 behave as if no key was pressed at all
    assign key_act    = key_valid && (key_code < 4'd12);
    assign is_cell    = |cell_sel;
    assign cell_taken = |(cell_sel & occupied);

    always_comb begin
        mark     = turn_q ? 2'd2 : 2'd1;
        cell_sel = '0;
        occupied = '0;
        mine     = '0;
        for (int k = 0; k < 9; k++) begin
            cell_sel[k] = (key_code == 4'(k + 1));
            occupied[k] = (board_q[2*k +: 2] != 2'd0);
            mine[k]     = (board_q[2*k +: 2] == mark);
        end
        win_mask = '0;
        for (int l = 0; l < 8; l++) begin
            if ((mine & LINES[l]) == LINES[l]) begin
                win_mask = win_mask | LINES[l];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        board_d       = board_q;
        board_right_d = board_right_q;
        turn_d        = turn_q;
        move_cnt_d    = move_cnt_q;
        winner_d      = winner_q;
        win_line_d    = win_line_q;
        timer_d       = timer_q;
        err_d         = 1'b0;
        timeout_d     = 1'b0;
        clr_game      = 1'b0;

        case (state_q)
            S_MAIN: begin
                if (key_act && key_code == K_STAR) begin
                    clr_game = 1'b1;
                    state_d  = S_PLAY;
                end else if (key_act && key_code == K_ZERO) begin
                    board_right_d = ~board_right_q;
                end
            end
            S_PLAY: begin
                if (key_act && is_cell) begin
                    if (cell_taken) begin
                        err_d = 1'b1;
                    end else begin
                        for (int k = 0; k < 9; k++) begin
                            if (cell_sel[k]) board_d[2*k +: 2] = mark;
                        end
                        move_cnt_d = move_cnt_q + 4'd1;
                        timer_d    = '0;
                        state_d    = S_CHECK;
                    end
                end else if (key_act && key_code == K_ZERO) begin
                    err_d = 1'b1;
                end else if (key_act && key_code == K_HASH) begin
                    clr_game = 1'b1;
                    state_d  = S_MAIN;
                end
                // a key landing on the expiry cycle wins; the timer then waits at its last value
                if (state_d == S_PLAY && TO_EN) begin
                    if (timer_q != TO_LAST) begin
                        timer_d = timer_q + CNT_W'(1);
                    end else if (!key_act) begin
                        turn_d    = ~turn_q;
                        timer_d   = '0;
                        timeout_d = 1'b1;
                    end
                end
            end
            S_CHECK: begin
                if (win_mask != 9'd0) begin
                    winner_d   = mark;
                    win_line_d = win_mask;
                    state_d    = S_OVER;
                end else if (move_cnt_q == 4'd9) begin
                    winner_d   = 2'd3;
                    win_line_d = '0;
                    state_d    = S_OVER;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = S_PLAY;
                end
            end
            default: begin
                if (key_act && key_code == K_STAR) begin
                    clr_game = 1'b1;
                    state_d  = S_PLAY;
                end else if (key_act && key_code == K_HASH) begin
                    clr_game = 1'b1;
                    state_d  = S_MAIN;
                end
            end
        endcase

        if (clr_game) begin
            board_d    = '0;
            move_cnt_d = '0;
            turn_d     = 1'b0;
            winner_d   = '0;
            win_line_d = '0;
            timer_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_MAIN;
            board_q       <= '0;
            board_right_q <= 1'b0;
            turn_q        <= 1'b0;
            move_cnt_q    <= '0;
            winner_q      <= '0;
            win_line_q    <= '0;
            err_q         <= 1'b0;
            timeout_q     <= 1'b0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            board_q       <= board_d;
            board_right_q <= board_right_d;
            turn_q        <= turn_d;
            move_cnt_q    <= move_cnt_d;
            winner_q      <= winner_d;
            win_line_q    <= win_line_d;
            err_q         <= err_d;
            timeout_q     <= timeout_d;
            timer_q       <= timer_d;
        end
    end

    assign board       = board_q;
    assign is_main     = (state_q == S_MAIN);
    assign board_right = board_right_q;
    assign turn_o      = turn_q;
    assign move_cnt    = move_cnt_q;
    assign game_over   = (state_q == S_OVER);
    assign winner      = winner_q;
    assign win_line    = win_line_q;
    assign err         = err_q;
    assign timeout     = timeout_q;
endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb/tb_ttt_game_ctrl.sv - self-checking bench for ttt_game_ctrl against a game-level reference model
module tb_ttt_game_ctrl;
    localparam int TO = 20;
    localparam int PH_MAIN  = 0;
    localparam int PH_PLAY  = 1;
    localparam int PH_CHECK = 2;
    localparam int PH_OVER  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [17:0] board;
    logic        is_main;
    logic        board_right;
    logic        turn_o;
    logic [3:0]  move_cnt;
    logic        game_over;
    logic [1:0]  winner;
    logic [8:0]  win_line;
    logic        err;
    logic        timeout;

    ttt_game_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .board(board), .is_main(is_main), .board_right(board_right), .turn_o(turn_o),
        .move_cnt(move_cnt), .game_over(game_over), .winner(winner), .win_line(win_line),
        .err(err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int m_board [9];
    int m_ph, m_turn, m_cnt, m_winner, m_line, m_right, m_err, m_to, m_timer;
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_board[k]) m_board[k] = 0;
        m_ph = PH_MAIN; m_turn = 0; m_cnt = 0; m_winner = 0; m_line = 0;
        m_right = 0; m_err = 0; m_to = 0; m_timer = 0;
    endtask

    task automatic model_new_game(input int ph);
        foreach (m_board[k]) m_board[k] = 0;
        m_ph = ph; m_turn = 0; m_cnt = 0; m_winner = 0; m_line = 0; m_timer = 0;
    endtask

    task automatic model_update(input logic kv, input int kc);
        bit act;
        bit moved;
        int p;
        act = kv && (kc < 12);
        m_err = 0;
        m_to = 0;
        p = m_turn ? 2 : 1;
        case (m_ph)
            PH_MAIN: begin
                if (act && kc == 10) model_new_game(PH_PLAY);
                else if (act && kc == 0) m_right = 1 - m_right;
            end
            PH_PLAY: begin
                moved = 0;
                if (act && kc >= 1 && kc <= 9) begin
                    if (m_board[kc-1] != 0) m_err = 1;
                    else begin
                        m_board[kc-1] = p;
                        m_cnt++;
                        m_timer = 0;
                        m_ph = PH_CHECK;
                        moved = 1;
                    end
                end else if (act && kc == 0) m_err = 1;
                else if (act && kc == 11) begin
                    model_new_game(PH_MAIN);
                    moved = 1;
                end
                if (!moved) begin
                    if (m_timer == TO - 1) begin
                        if (!act) begin
                            m_turn = 1 - m_turn;
                            m_timer = 0;
                            m_to = 1;
                        end
                    end else m_timer++;
                end
            end
            PH_CHECK: begin
                int mask;
                mask = 0;
                for (int l = 0; l < 8; l++)
                    if (m_board[lines[l][0]] == p && m_board[lines[l][1]] == p && m_board[lines[l][2]] == p)
                        for (int j = 0; j < 3; j++) mask |= (1 << lines[l][j]);
                if (mask != 0) begin
                    m_winner = p; m_line = mask; m_ph = PH_OVER;
                end else if (m_cnt == 9) begin
                    m_winner = 3; m_line = 0; m_ph = PH_OVER;
                end else begin
                    m_turn = 1 - m_turn; m_ph = PH_PLAY;
                end
            end
            default: begin
                if (act && kc == 10) model_new_game(PH_PLAY);
                else if (act && kc == 11) model_new_game(PH_MAIN);
            end
        endcase
    endtask

    function automatic logic [17:0] exp_board();
        logic [17:0] b;
        b = '0;
        for (int k = 0; k < 9; k++) b[2*k +: 2] = 2'(m_board[k]);
        return b;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".board"},     32'(board),       32'(exp_board()));
        check({tag, ".is_main"},   32'(is_main),     32'(m_ph == PH_MAIN));
        check({tag, ".right"},     32'(board_right), 32'(m_right));
        check({tag, ".turn"},      32'(turn_o),      32'(m_turn));
        check({tag, ".move_cnt"},  32'(move_cnt),    32'(m_cnt));
        check({tag, ".game_over"}, 32'(game_over),   32'(m_ph == PH_OVER));
        check({tag, ".winner"},    32'(winner),      32'(m_winner));
        check({tag, ".win_line"},  32'(win_line),    32'(m_line));
        check({tag, ".err"},       32'(err),         32'(m_err));
        check({tag, ".timeout"},   32'(timeout),     32'(m_to));
    endtask

    task automatic step(input logic kv, input logic [3:0] kc);
        key_valid = kv;
        key_code  = kc;
        @(posedge clk);
        model_update(kv, int'(kc));
        @(negedge clk);
        key_valid = 1'b0;
        compare_all("cyc");
    endtask

    task automatic play(input logic [3:0] kc);
        step(1'b1, kc);
        step(1'b0, 4'd0);
    endtask

    task automatic play_seq(input int seq [9], input int n);
        for (int i = 0; i < n; i++) play(4'(seq[i]));
    endtask

    initial begin
        int win_seq  [9] = '{1, 4, 2, 5, 3, 0, 0, 0, 0};
        int draw_seq [9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
        int diag_seq [9] = '{1, 3, 2, 4, 5, 7, 6, 8, 9};

        rst = 1'b0;
        key_valid = 1'b0;
        key_code = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("reset");
        check("reset_is_main", 32'(is_main), 32'd1);
        check("reset_board", 32'(board), 32'd0);
        rst = 1'b1;

        // X wins on the top row
        step(1'b1, 4'd10);
        check("t1_is_main", 32'(is_main), 32'd0);
        check("t1_turn", 32'(turn_o), 32'd0);
        play_seq(win_seq, 5);
        check("t1_game_over", 32'(game_over), 32'd1);
        check("t1_winner", 32'(winner), 32'd1);
        check("t1_win_line", 32'(win_line), 32'b000000111);
        check("t1_move_cnt", 32'(move_cnt), 32'd5);

        // full board, no line
        step(1'b1, 4'd10);
        check("t2_board_clear", 32'(board), 32'd0);
        play_seq(draw_seq, 9);
        check("t2_draw_winner", 32'(winner), 32'd3);
        check("t2_draw_line", 32'(win_line), 32'd0);
        check("t2_draw_cnt", 32'(move_cnt), 32'd9);
        check("t2_draw_over", 32'(game_over), 32'd1);

        // ninth move completes the main diagonal
        step(1'b1, 4'd10);
        play_seq(diag_seq, 9);
        check("t2_diag_winner", 32'(winner), 32'd1);
        check("t2_diag_line", 32'(win_line), 32'b100010001);

        // illegal keys in PLAY
        step(1'b1, 4'd10);
        play(4'd5);
        step(1'b1, 4'd5);
        check("t3_err_on", 32'(err), 32'd1);
        check("t3_cell5", 32'(board[9:8]), 32'd1);
        step(1'b0, 4'd0);
        check("t3_err_off", 32'(err), 32'd0);
        check("t3_cnt", 32'(move_cnt), 32'd1);
        check("t3_turn", 32'(turn_o), 32'd1);
        step(1'b1, 4'd0);
        check("t3_err_zero", 32'(err), 32'd1);
        step(1'b0, 4'd0);

        // turn timeout, then a key on the expiry cycle
        step(1'b1, 4'd11);
        step(1'b1, 4'd10);
        repeat (TO - 1) step(1'b0, 4'd0);
        check("t4_no_to_early", 32'(timeout), 32'd0);
        step(1'b0, 4'd0);
        check("t4_timeout", 32'(timeout), 32'd1);
        check("t4_turn", 32'(turn_o), 32'd1);
        step(1'b0, 4'd0);
        check("t4_to_pulse", 32'(timeout), 32'd0);
        step(1'b1, 4'd11);
        step(1'b1, 4'd10);
        repeat (TO - 1) step(1'b0, 4'd0);
        step(1'b1, 4'd3);
        check("t4_key_wins_to", 32'(timeout), 32'd0);
        check("t4_cell3_x", 32'(board[5:4]), 32'd1);
        step(1'b0, 4'd0);

        // abort, board_right toggle, restart from OVER
        step(1'b1, 4'd11);
        check("t5_abort_main", 32'(is_main), 32'd1);
        check("t5_abort_board", 32'(board), 32'd0);
        step(1'b1, 4'd0);
        check("t5_right_1", 32'(board_right), 32'd1);
        step(1'b1, 4'd0);
        check("t5_right_0", 32'(board_right), 32'd0);
        step(1'b1, 4'd10);
        play_seq(win_seq, 5);
        step(1'b1, 4'd10);
        check("t5_restart_board", 32'(board), 32'd0);
        check("t5_restart_turn", 32'(turn_o), 32'd0);
        check("t5_restart_over", 32'(game_over), 32'd0);

        // asynchronous reset while in CHECK
        step(1'b1, 4'd1);
        key_valid = 1'b1;
        key_code = 4'd2;
        @(posedge clk);
        model_update(1'b1, 2);
        #2;
        key_valid = 1'b0;
        rst = 1'b0;
        #1;
        model_reset();
        check("t6_rst_board", 32'(board), 32'd0);
        check("t6_rst_main", 32'(is_main), 32'd1);
        check("t6_rst_cnt", 32'(move_cnt), 32'd0);
        compare_all("t6");
        @(negedge clk);
        rst = 1'b1;

        // randomized play against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic kv;
            logic [3:0] kc;
            kv = ($urandom_range(0, 99) < ((i < 1500) ? 35 : 8));
            r = $urandom_range(0, 99);
            if (r < 60)      kc = 4'($urandom_range(1, 9));
            else if (r < 72) kc = 4'd10;
            else if (r < 80) kc = 4'd11;
            else if (r < 88) kc = 4'd0;
            else             kc = 4'($urandom_range(12, 15));
            step(kv, kc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ttt_game_ctrl.md
Name: ttt_game_ctrl

Overview:
Game controller for the tic-tac-toe board. It consumes decoded keypad events and owns the 3x3 board state, the turn, and the move counter. It detects win, draw and per-turn timeout, and sequences MAIN/PLAY/CHECK/OVER. Its outputs drive the dot-matrix and 7-segment renderers; it sits between keypad_scan and the display blocks in the top level.

Parameters:
TIMEOUT_CYC, 500000000, cycles allowed per turn before the turn is forfeited (10 s at 50 MHz); 0 disables the timeout.
CNT_W, 32, width of the turn-timer counter; must hold TIMEOUT_CYC.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
key_valid  input  1  single-cycle pulse: one debounced key press
key_code  input  4  key id: 1..9 = board cell (row-major, 1 = top-left), 0 = key '0', 10 = '*', 11 = '#', 12..15 unused
board  output  18  cell k (k = key-1) at [2k+1:2k]: 0 empty, 1 X, 2 O
is_main  output  1  1 = title/idle screen
board_right  output  1  board drawn on right half of dot matrix
turn_o  output  1  1 = O to move, 0 = X to move
move_cnt  output  4  stones placed, 0..9
game_over  output  1  1 while in OVER
winner  output  2  0 none, 1 X, 2 O, 3 draw
win_line  output  9  bit k set = cell k is part of the winning line(s)
err  output  1  1-cycle pulse on illegal key in PLAY
timeout  output  1  1-cycle pulse when a turn is forfeited

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst.
- Reset values: state=MAIN, board=0, is_main=1, board_right=0, turn_o=0, move_cnt=0, game_over=0, winner=0, win_line=0, err=0, timeout=0, timer=0.
- Reset asserted mid-game discards all game state immediately.
- States: MAIN, PLAY, CHECK, OVER. Only keys with key_valid=1 are acted on; codes 12..15 are always ignored with no err.
- MAIN:
  - '*' -> clear board, move_cnt=0, turn_o=0, winner=0, win_line=0, timer=0, go to PLAY.
  - '0' -> toggle board_right.
  - All other keys ignored.
  - is_main=1 only in MAIN.
- PLAY, key 1..9 on an empty cell:
  - Write 1 (X) or 2 (O) per turn_o into that cell.
  - move_cnt+1, timer=0, go to CHECK.
  - board is updated at the first edge after key_valid.
- PLAY, other keys:
  - Key 1..9 on an occupied cell, or key '0' -> err pulse for 1 cycle; no other change.
  - '#' -> abort: clear board and counters, go to MAIN.
  - '*' ignored.
- PLAY timer:
  - timer increments each cycle.
  - When timer == TIMEOUT_CYC-1: toggle turn_o, timer=0, timeout pulse.
  - If key_valid arrives in the same cycle, the key is processed for the current player and no timeout occurs.
  - With TIMEOUT_CYC=0 the timer is held at 0.
- CHECK (exactly 1 cycle; key_valid is dropped):
  - Evaluate the 8 lines (3 rows, 3 columns, 2 diagonals) for the player who just moved.
  - Any line complete -> winner=1/2, win_line = OR of all complete lines' masks, go to OVER.
  - Else if move_cnt==9 -> winner=3, win_line=0, go to OVER.
  - Else toggle turn_o, go to PLAY.
- Latency: key_valid at edge n -> board at n+1 -> game_over/winner at n+2.
- A 9th move that also completes a line is a win, not a draw.
- OVER:
  - game_over=1; board, winner and win_line are held.
  - '*' -> new game exactly as from MAIN '*' (X first).
  - '#' -> clear board and go to MAIN.
  - All other keys ignored; no timeout in OVER.
- err and timeout are never both asserted in one cycle.

Test Plan:
1. Reset, then '*' -> is_main=0, state PLAY, board=0, turn_o=0. Keys 1,4,2,5,3 -> after the 5th key plus 2 cycles: game_over=1, winner=1, win_line=9'b000000111, move_cnt=5.
2. Draw sequence 1,2,3,5,4,6,8,7,9 -> winner=3, win_line=0, move_cnt=9, game_over=1. Separately, a 9th move that completes the diagonal 1,5,9 -> winner=1, not 3.
3. In PLAY press 5, then 5 again -> second press gives err=1 for exactly 1 cycle, board[9:8]=1, move_cnt=1, turn_o still 1. Key '0' in PLAY -> err pulse.
4. TIMEOUT_CYC=20: enter PLAY and idle -> timeout pulse at cycle 20, turn_o=1. Key 3 landing on the timeout cycle -> cell 3 gets X, no timeout pulse.
5. In MAIN press '0' twice -> board_right goes 1 then 0. In PLAY press '#' mid-game -> is_main=1, board=0. In OVER press '*' -> new game, board=0, turn_o=0.
6. Assert rst low mid-CHECK (asynchronously, between edges) -> all outputs take reset values without waiting for a clk edge.
